// File: rtl/bf_result_streamer.sv
// Streams the Bellman-Ford distance table in address order on a valid/ready port and gathers stats.
// Optional running checksum of scanned words when RESULT_CHECKSUM_EN is defined.
module bf_result_streamer #(
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 16,
    parameter int                NUM_NODES = 8192,
    parameter logic [DATA_W-1:0] UNREACH   = {DATA_W{1'b1}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              neg_cycle,
    output logic [ADDR_W-1:0] OMAR,
    input  logic [DATA_W-1:0] OMDR,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_neg,
    output logic              done,
    output logic [13:0]       unreach_count,
    output logic [DATA_W-1:0] max_dist,
    output logic [DATA_W-1:0] checksum
);

    // state | meaning
    // IDLE  | waiting for a rising edge on start
    // NEG   | presenting the single negative-cycle marker beat
    // SCAN  | reading Output Memory, one entry per free output slot
    // DRAIN | last entry loaded, waiting for it to be accepted
    // DONE  | run complete, waiting for start to drop
    typedef enum logic [2:0] {IDLE, NEG, SCAN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NODES - 1);

    state_t            state, state_nxt;
    logic              start_q;
    logic              start_edge;
    logic              clr_stats;
    logic              scan_load;
    logic              neg_load;
    logic              drop_beat;
    logic [ADDR_W-1:0] idx;

    assign start_edge = start & ~start_q;
    assign OMAR       = idx;
    assign done       = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_stats = 1'b0;
        scan_load = 1'b0;
        neg_load  = 1'b0;
        drop_beat = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    clr_stats = 1'b1;
                    state_nxt = neg_cycle ? NEG : SCAN;
                end
            end
            NEG: begin
                if (!out_valid) begin
                    neg_load = 1'b1;
                end else if (out_ready) begin
                    drop_beat = 1'b1;
                    state_nxt = DONE;
                end
            end
            SCAN: begin
                // the output slot frees up in the same cycle it is accepted
                if (!out_valid || out_ready) begin
                    scan_load = 1'b1;
                    if (idx == LAST_IDX) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    drop_beat = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q       <= 1'b0;
            idx           <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            out_neg       <= 1'b0;
            unreach_count <= '0;
            max_dist      <= '0;
        end else begin
            start_q <= start;
            if (clr_stats) begin
                idx           <= '0;
                unreach_count <= '0;
                max_dist      <= '0;
            end
            if (neg_load) begin
                out_valid <= 1'b1;
                out_data  <= UNREACH;
                out_last  <= 1'b1;
                out_neg   <= 1'b1;
            end
            if (scan_load) begin
                out_valid <= 1'b1;
                out_data  <= OMDR;
                out_last  <= (idx == LAST_IDX);
                out_neg   <= 1'b0;
                idx       <= idx + 1'b1;
                if (OMDR == UNREACH)     unreach_count <= unreach_count + 14'd1;
                else if (OMDR > max_dist) max_dist     <= OMDR;
            end
            if (drop_beat) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_neg   <= 1'b0;
            end
        end
    end

`ifdef RESULT_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          checksum <= '0;
        else if (clr_stats) checksum <= '0;
        else if (scan_load) checksum <= checksum + OMDR;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_bf_result_streamer.sv
// Directed + randomized bench for bf_result_streamer on a 4-entry table.
// Expected beats and stats come from a queue/loop reference model of the scan.
module tb_bf_result_streamer;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam int N      = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              neg_cycle = 1'b0;
    logic [ADDR_W-1:0] OMAR;
    logic [DATA_W-1:0] OMDR;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_neg;
    logic              done;
    logic [13:0]       unreach_count;
    logic [DATA_W-1:0] max_dist;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] mem [N];
    int n_cmp = 0;
    int n_err = 0;

    bf_result_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_NODES(N)) dut (
        .clock(clock), .reset(reset), .start(start), .neg_cycle(neg_cycle),
        .OMAR(OMAR), .OMDR(OMDR), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_neg(out_neg), .done(done),
        .unreach_count(unreach_count), .max_dist(max_dist), .checksum(checksum)
    );

    assign OMDR = (OMAR < ADDR_W'(N)) ? mem[OMAR[1:0]] : 16'h0000;

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // mode 0: ready always high, 1: alternating, 2: random
    task automatic do_run(input bit neg, input int mode, input string tag);
        logic [DATA_W-1:0] exp_data[$];
        logic [DATA_W-1:0] got_data[$];
        bit                got_last[$];
        bit                got_neg[$];
        logic [13:0]       exp_unr = '0;
        logic [DATA_W-1:0] exp_max = '0;
        logic [DATA_W-1:0] exp_sum = '0;
        int first_valid = -1;
        int done_cyc = -1;
        bit stalled = 1'b0;
        bit omar_moved = 1'b0;
        logic [DATA_W-1:0] hold_data = '0;
        bit hold_last = 1'b0;
        bit hold_neg = 1'b0;

        if (neg) begin
            exp_data.push_back(16'hFFFF);
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_data.push_back(mem[i]);
                if (mem[i] == 16'hFFFF) exp_unr++;
                else if (mem[i] > exp_max) exp_max = mem[i];
`ifdef RESULT_CHECKSUM_EN
                exp_sum = exp_sum + mem[i];
`endif
            end
        end

        @(negedge clock);
        start = 1'b1;
        neg_cycle = neg;
        out_ready = pick_ready(mode, 0);
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            @(negedge clock);
            if (stalled) begin
                chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_stall_data"}, 32'(out_data), 32'(hold_data));
                chk({tag, "_stall_last"}, 32'(out_last), 32'(hold_last));
                chk({tag, "_stall_neg"}, 32'(out_neg), 32'(hold_neg));
            end
            if (neg && OMAR != '0) omar_moved = 1'b1;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done && done_cyc < 0) done_cyc = cyc;
            out_ready = pick_ready(mode, cyc);
            #1;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_neg.push_back(out_neg);
            end
            stalled   = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
            hold_neg  = out_neg;
        end

        chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        chk({tag, "_beat_count"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == exp_data.size() - 1));
            chk($sformatf("%s_neg%0d", tag, i), 32'(got_neg[i]), 32'(neg));
        end
        chk({tag, "_valid_in_done"}, 32'(out_valid), 32'd0);
        chk({tag, "_unreach"}, 32'(unreach_count), 32'(exp_unr));
        chk({tag, "_max"}, 32'(max_dist), 32'(exp_max));
        chk({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
        if (neg) chk({tag, "_omar_held"}, 32'(omar_moved), 32'd0);
        if (mode == 0) begin
            chk({tag, "_first_valid_lat"}, 32'(first_valid), 32'd2);
            chk({tag, "_done_lat"}, 32'(done_cyc), neg ? 32'd3 : 32'(N + 2));
        end

        @(negedge clock);
        chk({tag, "_done_held"}, 32'(done), 32'd1);
        start = 1'b0;
        neg_cycle = 1'b0;
        @(negedge clock);
        chk({tag, "_done_cleared"}, 32'(done), 32'd0);
        chk({tag, "_unreach_hold"}, 32'(unreach_count), 32'(exp_unr));
        chk({tag, "_max_hold"}, 32'(max_dist), 32'(exp_max));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_neg"}, 32'(out_neg), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_omar"}, 32'(OMAR), 32'd0);
        chk({tag, "_unreach"}, 32'(unreach_count), 32'd0);
        chk({tag, "_max"}, 32'(max_dist), 32'd0);
        chk({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        mem[0] = 16'h0000; mem[1] = 16'h0005; mem[2] = 16'hFFFF; mem[3] = 16'h0003;
        repeat (3) @(negedge clock);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);

        do_run(1'b0, 0, "basic");
        do_run(1'b0, 1, "toggle");
        do_run(1'b1, 0, "negcyc");
        do_run(1'b1, 1, "negcyc_stall");

        for (int i = 0; i < N; i++) mem[i] = 16'hFFFF;
        do_run(1'b0, 0, "all_unreach");
        do_run(1'b0, 2, "all_unreach_rerun");

        mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'hFFFF; mem[3] = 16'h0004;
        do_run(1'b0, 0, "sum");

        // abort after the third beat (index 2) is accepted
        @(negedge clock);
        start = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk_reset_values("midrun_reset");
        @(negedge clock);
        chk_reset_values("midrun_reset_edge");
        reset = 1'b0;
        @(negedge clock);
        chk({"after_reset_idle"}, 32'(out_valid), 32'd0);
        do_run(1'b0, 1, "after_reset");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
            do_run(($urandom_range(0, 5) == 0), 2, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
